pipelined_rca: RTL and testbench
================================

// Module: pipelined_rca
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor; successor to the 4-bit fulladder.
//   Splits a WIDTH-bit add into STAGES = WIDTH/CHUNK register-separated ripple chunks.
//   Accepts one operand set per cycle, with valid/ready handshakes on input and output.
//   Sits between an operand source and a result sink that may apply backpressure.
// PARAMETERS
//   WIDTH   16   operand/result width in bits
//   CHUNK   4    bits added per pipeline stage; WIDTH % CHUNK must be 0
//   STAGES  WIDTH/CHUNK (localparam) pipeline depth = latency in cycles
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operand set on i0/i1/cin/sub is valid
//   in_ready   out  1      block can accept an operand set this cycle
//   i0         in   WIDTH  operand A
//   i1         in   WIDTH  operand B
//   cin        in   1      carry-in (borrow-in when sub=1)
//   sub        in   1      0: o = i0+i1+cin; 1: o = i0-i1-cin
//   out_valid  out  1      o/cout hold a valid result
//   out_ready  in   1      sink accepts result this cycle
//   o          out  WIDTH  sum/difference, modulo 2^WIDTH
//   cout       out  1      carry-out of MSB (sub: 1 = no borrow)
// BEHAVIOUR
//   - Reset: all stage valid bits, out_valid, o, cout (and ovf) cleared to 0; in_ready=1 on the
//     cycle after reset deasserts. Reset mid-operation discards all in-flight results; no
//     out_valid pulse follows.
//   - Global advance: en = !out_valid | out_ready. in_ready = en (combinational).
//     When en=0, every stage register holds. When en=1, all stages shift by one.
//     Bubbles (stage valid=0) shift like data; no bubble collapsing.
//   - Transfer: an input is taken when in_valid & in_ready. A result is consumed when
//     out_valid & out_ready.
//   - Subtract: B' = sub ? ~i1 : i1; c0 = sub ? ~cin : cin. sub is captured with operands.
//   - Stage k (0..STAGES-1) adds chunk k of A and B' plus carry from stage k-1 (c0 for k=0).
//     It registers the chunk sum and the chunk carry.
//     Unconsumed upper chunks of A/B' and completed lower sum chunks travel with the data.
//   - Latency: STAGES cycles from accepted input to out_valid with no stalls.
//     Throughput: 1 result/cycle.
//   - Ordering: results emerge in acceptance order; no loss or duplication under any
//     out_ready pattern.
//   - o/cout stable while out_valid=1 and out_ready=0.
//   - CHUNK==WIDTH degenerates to a single registered stage (latency 1).
//   - in_valid=0 with en=1 inserts a bubble. o/cout values are don't-care when out_valid=0
//     but are not X after reset.
// CONFIGURATION
//   RCA_OVERFLOW_EN defined: extra port ovf (out, 1).
//     ovf = carry into MSB XOR carry out of MSB (signed two's-complement overflow).
//     Registered and stalled alongside o; reset 0.
//   RCA_OVERFLOW_EN undefined: no ovf port and no related logic.
// TESTING (WIDTH=16, CHUNK=4, latency 4)
//   - 0x00FF+0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, o=0x0100, cout=0.
//   - 0xFFFF+0x0000, cin=1 -> o=0x0000, cout=1 (carry ripples through all 4 stages).
//   - sub=1, 0x0005-0x0007, cin=0 -> o=0xFFFE, cout=0.
//     Then 0x0009-0x0003 -> o=0x0006, cout=1.
//   - 3 back-to-back inputs, out_ready=0 for 2 cycles after first out_valid:
//     o held, in_ready=0 while stalled; all 3 results delivered in order.
//   - Reset asserted 2 cycles after accepting an input -> out_valid stays 0 for the following
//     6 cycles.
//   - RCA_OVERFLOW_EN: 0x7FFF+0x0001 -> o=0x8000, ovf=1.
//     0x0001+0x0001 -> ovf=0.

Source files
------------

// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for pipelined_rca.
// With RCA_OVERFLOW_EN defined, the bundle also carries the signed-overflow flag ovf.
interface pipelined_rca_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             cout;
`ifdef RCA_OVERFLOW_EN
    logic             ovf;

    modport slave (
        input  in_valid, i0, i1, cin, sub, out_ready,
        output in_ready, out_valid, o, cout, ovf
    );
    modport master (
        output in_valid, i0, i1, cin, sub, out_ready,
        input  in_ready, out_valid, o, cout, ovf
    );
`else
    modport slave (
        input  in_valid, i0, i1, cin, sub, out_ready,
        output in_ready, out_valid, o, cout
    );
    modport master (
        output in_valid, i0, i1, cin, sub, out_ready,
        input  in_ready, out_valid, o, cout
    );
`endif
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit ripple per stage, valid/ready on both ends.
// Optional RCA_OVERFLOW_EN adds a registered signed-overflow output (ovf).
module pipelined_rca #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4  // WIDTH must be a multiple of CHUNK
) (
    input logic            clk,
    input logic            reset,
    pipelined_rca_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic en;

    // Stage inputs (from previous stage register, or the bus for stage 0)
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];

    // Stage results before registering
    logic [CHUNK:0]   part  [STAGES];
    logic [WIDTH-1:0] s_nx  [STAGES];

    // Stage registers
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];
    logic             c_q     [STAGES];

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    always_comb begin
        v_in[0] = bus.in_valid;
        a_in[0] = bus.i0;
        b_in[0] = bus.sub ? ~bus.i1 : bus.i1;
        c_in[0] = bus.sub ? ~bus.cin : bus.cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = valid_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end
    end

    // Bubbles shift like data; the whole pipe holds when the output is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                c_q[k]     <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= v_in[k];
                a_q[k]     <= a_in[k];
                b_q[k]     <= b_in[k];
                s_q[k]     <= s_nx[k];
                c_q[k]     <= part[k][CHUNK];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.o         = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];

`ifdef RCA_OVERFLOW_EN
    logic msb_carry_in;
    logic ovf_q;

    // Carry into the MSB recovered from the MSB sum bit and its operands
    assign msb_carry_in = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                        ^ s_nx[STAGES-1][WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= msb_carry_in ^ part[STAGES-1][CHUNK];
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca (WIDTH=16, CHUNK=4, latency 4).
// Build with RCA_OVERFLOW_EN defined to also exercise the ovf output.
module tb_pipelined_rca;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    pipelined_rca_if #(.WIDTH(16)) bus ();

    pipelined_rca #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: issue one operand set into an empty pipe, return what appears 4 edges later
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic s, output logic v, output logic [15:0] r,
                           output logic co);
        bus.i0 = a;
        bus.i1 = b;
        bus.cin = c;
        bus.sub = s;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        v = bus.out_valid;
        r = bus.o;
        co = bus.cout;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.o !== 16'h0000) $display("FAIL reset_o got %h want 0000", bus.o);
        else n_pass++;
        n_checks++;
        if (bus.cout !== 1'b0) $display("FAIL reset_cout got %b want 0", bus.cout);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_add_latency();
        bus.i0 = 16'h00FF;
        bus.i1 = 16'h0001;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL add_early_valid cycle %0d got %b want 0", i, bus.out_valid);
            else n_pass++;
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.o !== 16'h0100) $display("FAIL add_o got %h want 0100", bus.o);
        else n_pass++;
        n_checks++;
        if (bus.cout !== 1'b0) $display("FAIL add_cout got %b want 0", bus.cout);
        else n_pass++;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_carry_chain();
        logic [15:0] a_v [3] = '{16'hFFFF, 16'h1234, 16'h8000};
        logic [15:0] b_v [3] = '{16'h0000, 16'h4321, 16'h8000};
        logic        c_v [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] r_v [3] = '{16'h0000, 16'h5555, 16'h0000};
        logic        k_v [3] = '{1'b1, 1'b0, 1'b1};
        logic        v;
        logic [15:0] r;
        logic        co;
        for (int i = 0; i < 3; i++) begin
            run_one(a_v[i], b_v[i], c_v[i], 1'b0, v, r, co);
            n_checks++;
            if (v !== 1'b1 || r !== r_v[i])
                $display("FAIL carry_o vec %0d got v=%b o=%h want v=1 o=%h", i, v, r, r_v[i]);
            else n_pass++;
            n_checks++;
            if (co !== k_v[i]) $display("FAIL carry_cout vec %0d got %b want %b", i, co, k_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_subtract();
        logic [15:0] a_v [3] = '{16'h0005, 16'h0009, 16'h0010};
        logic [15:0] b_v [3] = '{16'h0007, 16'h0003, 16'h0004};
        logic        c_v [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] r_v [3] = '{16'hFFFE, 16'h0006, 16'h000B};
        logic        k_v [3] = '{1'b0, 1'b1, 1'b1};
        logic        v;
        logic [15:0] r;
        logic        co;
        for (int i = 0; i < 3; i++) begin
            run_one(a_v[i], b_v[i], c_v[i], 1'b1, v, r, co);
            n_checks++;
            if (v !== 1'b1 || r !== r_v[i])
                $display("FAIL sub_o vec %0d got v=%b o=%h want v=1 o=%h", i, v, r, r_v[i]);
            else n_pass++;
            n_checks++;
            if (co !== k_v[i]) $display("FAIL sub_cout vec %0d got %b want %b", i, co, k_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_v [3] = '{16'h0001, 16'h0010, 16'h0100};
        logic [15:0] b_v [3] = '{16'h0002, 16'h0020, 16'h0200};
        logic [15:0] r_v [3] = '{16'h0003, 16'h0030, 16'h0300};
        logic [15:0] got [4];
        int          cnt;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i0 = a_v[i];
            bus.i1 = b_v[i];
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.o !== 16'h0003)
            $display("FAIL b2b_first got v=%b o=%h want v=1 o=0003", bus.out_valid, bus.o);
        else n_pass++;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", bus.in_ready);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.o !== 16'h0003)
                $display("FAIL b2b_hold cycle %0d got v=%b o=%h want v=1 o=0003",
                         i, bus.out_valid, bus.o);
            else n_pass++;
            n_checks++;
            if (bus.in_ready !== 1'b0)
                $display("FAIL b2b_stall_ready cycle %0d got %b want 0", i, bus.in_ready);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid === 1'b1) begin
                if (cnt < 4) got[cnt] = bus.o;
                cnt++;
            end
            step();
        end
        n_checks++;
        if (cnt !== 3) $display("FAIL b2b_count got %0d want 3", cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= cnt) $display("FAIL b2b_order idx %0d got none want %h", i, r_v[i]);
            else if (got[i] !== r_v[i])
                $display("FAIL b2b_order idx %0d got %h want %h", i, got[i], r_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_flush();
        bus.i0 = 16'h0001;
        bus.i1 = 16'h0001;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL flush_valid cycle %0d got %b want 0", i, bus.out_valid);
            else n_pass++;
            step();
        end
    endtask

`ifdef RCA_OVERFLOW_EN
    task automatic test_overflow();
        logic        v;
        logic [15:0] r;
        logic        co;
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, v, r, co);
        n_checks++;
        if (v !== 1'b1 || r !== 16'h8000)
            $display("FAIL ovf_sum got v=%b o=%h want v=1 o=8000", v, r);
        else n_pass++;
        n_checks++;
        if (bus.ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.ovf);
        else n_pass++;
        run_one(16'h0001, 16'h0001, 1'b0, 1'b0, v, r, co);
        n_checks++;
        if (bus.ovf !== 1'b0 || r !== 16'h0002)
            $display("FAIL ovf_clear got ovf=%b o=%h want ovf=0 o=0002", bus.ovf, r);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.i0 = '0;
        bus.i1 = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_latency();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_reset_flush();
`ifdef RCA_OVERFLOW_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
